instr_fetch_stage: RTL and testbench
====================================

# instr_fetch_stage

Parametrised instruction fetch stage for the MIPS CPU. It first runs a preload phase that writes a program image word-by-word into the instruction memory. It then fetches sequentially from `PC_BASE_ADDR` through the synchronous-read memory. Instructions go to decode over a valid/ready handshake, with a 2-entry skid buffer and branch/jump redirect with flush.

## Interface
- `PC_BASE_ADDR`, 32'h0: load start address and fetch start address.
- `ADDR_W`, 32: PC / memory address width.
- `DATA_W`, 32: instruction width.
- `MAX_WORDS`, 1024: preload capacity in words; load index counter width is clog2(MAX_WORDS)+1.
- `clock`, in, 1: single clock, all state on posedge.
- `reset`, in, 1: synchronous, active-high.
- `load_valid`, in, 1: load word present this cycle (honoured in LOAD only).
- `load_data`, in, DATA_W: word to write.
- `load_last`, in, 1: qualifies the final load word.
- `load_count`, out, clog2(MAX_WORDS)+1: words accepted so far.
- `load_err`, out, 1: sticky; a load word arrived at index >= MAX_WORDS.
- `fetching`, out, 1: state == FETCH.
- `mem_addr`, out, ADDR_W: memory address.
- `mem_data_in`, out, DATA_W: memory write data.
- `mem_rw`, out, 1: 0 = write, 1 = read.
- `mem_en`, out, 1: memory access strobe.
- `mem_data_out`, in, DATA_W: read data, valid the cycle after a read strobe.
- `redirect_valid`, in, 1: change fetch stream.
- `redirect_pc`, in, ADDR_W: new PC; bits [1:0] are ignored (treated as 0).
- `instr_valid`, out, 1: skid-buffer head valid.
- `instr_ready`, in, 1: decode accepts the head.
- `instr`, out, DATA_W: head instruction.
- `instr_pc`, out, ADDR_W: PC of the head instruction.

## Operation
- **States:** LOAD, then FETCH. There is no return to LOAD except via `reset`.
- **LOAD:**
  - `mem_en` = `load_valid`, `mem_rw` = 0.
  - `mem_addr` = `PC_BASE_ADDR` + 4*`load_count`; `mem_data_in` = `load_data`.
  - Each accepted word increments `load_count`.
  - Index >= `MAX_WORDS`: `mem_en` is forced to 0, the word is dropped, `load_err` is set, and `load_count` saturates at `MAX_WORDS`.
  - `load_valid` && `load_last`: after this word, the next state is FETCH and `fetch_pc` <= `PC_BASE_ADDR`.
  - `load_last` without `load_valid` is ignored.
- **FETCH:**
  - `mem_rw` = 1, `mem_addr` = `fetch_pc`.
  - Load inputs are ignored.
- **Issue rule:**
  - credit = 2 - occupancy - inflight + pop, where pop = `instr_valid` && `instr_ready`.
  - `mem_en` = (credit > 0) && !`redirect_valid`.
  - On issue: `fetch_pc` += 4 (modulo 2^ADDR_W); inflight <= 1 with tag = the issued PC.
- **Capture:** in the cycle after an issue, `mem_data_out` and its tag are pushed into the skid buffer. The buffer can never overflow by construction; overflow is an assertion failure.
- **Redirect (FETCH only):**
  - At the edge: buffer emptied, inflight cleared (the returning data is discarded), `fetch_pc` <= {`redirect_pc`[ADDR_W-1:2], 2'b00}.
  - No issue occurs in the redirect cycle.
  - A handshake completing in the redirect cycle counts as accepted.
  - Redirect overrides issue and capture in the same cycle.
  - In LOAD, redirect is ignored.
- **Output ordering:** `instr`/`instr_pc` come from the buffer head, in strict fetch order.

## Timing
- **Reset values:**
  - State LOAD.
  - `load_count` 0, `load_err` 0, `fetching` 0, `instr_valid` 0.
  - `mem_en` 0, `mem_rw` 0, `mem_addr` = `PC_BASE_ADDR`.
  - Buffer empty, inflight 0.
- **Reset mid-operation:** same as above. Instruction memory contents are external and untouched.
- **Load throughput:** 1 word/cycle; the write is performed in the cycle `load_valid` is high.
- **LOAD to FETCH:** FETCH begins the cycle after `load_last`. The first read issues in that cycle (cycle F). `instr_valid` rises at F+2 with `instr_pc` = `PC_BASE_ADDR`.
- **Steady state:** with `instr_ready` held high, one instruction per cycle, PCs consecutive +4.
- **Stall:** with `instr_ready` low, at most 2 buffered + 0 inflight. `mem_en` drops once credit hits 0. The head holds stable while valid && !ready.
- **Redirect latency:** redirect in cycle R gives issue of the target at R+1 and `instr_valid` for the target at R+3. No stale PC appears after R.

## Test plan
- **Preload:** load 4 words 0x20080005, 0x20090007, 0x01095020, 0x00000000 with `load_last` on word 4 -> writes at 0x0, 0x4, 0x8, 0xC with `mem_rw` = 0; `load_count` = 4; `fetching` = 1 next cycle.
- **Streaming:** `instr_ready` = 1 after that load -> `instr_valid` rises 2 cycles after FETCH entry; `instr_pc` 0x0, 0x4, 0x8, 0xC on consecutive cycles with matching data.
- **Stall:** `instr_ready` = 0 for 5 cycles mid-stream -> `mem_en` low after 2 buffered; head held; on release no PC skipped or duplicated.
- **Redirect:** redirect to 0x41 at cycle R -> next issued `mem_addr` = 0x40 at R+1; `instr_pc` = 0x40 at R+3; no PC from the old stream after R.
- **Overflow:** `MAX_WORDS` = 4, load 6 words -> only 4 writes; `load_err` = 1 and stays 1; `load_count` = 4.
- **Reset mid-fetch:** `reset` for 1 cycle -> state LOAD, `instr_valid` 0, `load_count` 0, `load_err` 0; a reload then restarts fetch at `PC_BASE_ADDR`.

Source files
------------

// File: rtl/instr_fetch_stage_if.sv
// Bus bundle between the instruction fetch stage and its neighbours:
// program loader, instruction memory, redirect source and decode.
interface instr_fetch_stage_if #(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned MAX_WORDS = 1024
);
    localparam int unsigned CNT_W = $clog2(MAX_WORDS) + 1;

    // program preload
    logic              load_valid;
    logic [DATA_W-1:0] load_data;
    logic              load_last;
    logic [CNT_W-1:0]  load_count;
    logic              load_err;
    logic              fetching;

    // instruction memory port
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data_in;
    logic              mem_rw;
    logic              mem_en;
    logic [DATA_W-1:0] mem_data_out;

    // control-flow redirect
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;

    // instruction stream to decode
    logic              instr_valid;
    logic              instr_ready;
    logic [DATA_W-1:0] instr;
    logic [ADDR_W-1:0] instr_pc;

    // fetch stage side
    modport master (
        input  load_valid, load_data, load_last,
        input  mem_data_out,
        input  redirect_valid, redirect_pc,
        input  instr_ready,
        output load_count, load_err, fetching,
        output mem_addr, mem_data_in, mem_rw, mem_en,
        output instr_valid, instr, instr_pc
    );

    // environment side (loader, memory, decode)
    modport slave (
        output load_valid, load_data, load_last,
        output mem_data_out,
        output redirect_valid, redirect_pc,
        output instr_ready,
        input  load_count, load_err, fetching,
        input  mem_addr, mem_data_in, mem_rw, mem_en,
        input  instr_valid, instr, instr_pc
    );
endinterface

// File: rtl/instr_fetch_stage.sv
// Instruction fetch stage: preloads a program image into the instruction
// memory, then fetches sequentially through the synchronous-read memory into
// a 2-entry skid buffer feeding decode, with redirect/flush support.
module instr_fetch_stage #(
    parameter int unsigned        ADDR_W       = 32,
    parameter int unsigned        DATA_W       = 32,
    parameter int unsigned        MAX_WORDS    = 1024,
    parameter logic [ADDR_W-1:0]  PC_BASE_ADDR = '0
) (
    input  logic                clock,
    input  logic                reset,
    instr_fetch_stage_if.master bus
);
    localparam int unsigned      CNT_W   = $clog2(MAX_WORDS) + 1;
    localparam int unsigned      DEPTH   = 2;
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WORDS);

    typedef enum logic {
        S_LOAD  = 1'b0,
        S_FETCH = 1'b1
    } state_t;

    state_t state;
    state_t state_nxt;

    // loader state
    logic [CNT_W-1:0]  load_count;
    logic              load_err;
    logic              load_full;
    logic [ADDR_W-1:0] load_addr;
    logic              load_accept;
    logic              load_drop;
    logic              load_done;

    // fetch pointer and the single outstanding read
    logic [ADDR_W-1:0] fetch_pc;
    logic              inflight;
    logic [ADDR_W-1:0] inflight_pc;
    logic              issue;
    logic              flush;
    logic              has_credit;

    // skid buffer, entry 0 is the head
    logic [1:0]        occ;
    logic [DATA_W-1:0] buf_data [DEPTH];
    logic [ADDR_W-1:0] buf_pc   [DEPTH];
    logic              pop;
    logic              push;
    logic              wr_idx;

    assign pop       = (occ != 2'd0) && bus.instr_ready;
    assign push      = inflight;
    assign load_full = (load_count >= MAX_CNT);
    assign load_addr = PC_BASE_ADDR + (ADDR_W'(load_count) << 2);

    // Free slots counting a head leaving this cycle; an issue must leave
    // room for its data one cycle later.
    assign has_credit = ({1'b0, occ} + {2'b00, inflight}) < (3'd2 + {2'b00, pop});

    // Captured word lands behind whatever survives this cycle's pop.
    assign wr_idx = (occ == 2'd2) || ((occ == 2'd1) && !pop);

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= S_LOAD;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and memory-port control for the load and fetch phases.
    always_comb begin
        state_nxt       = state;
        bus.mem_en      = 1'b0;
        bus.mem_rw      = 1'b0;
        bus.mem_addr    = PC_BASE_ADDR;
        bus.mem_data_in = bus.load_data;
        load_accept     = 1'b0;
        load_drop       = 1'b0;
        load_done       = 1'b0;
        issue           = 1'b0;
        flush           = 1'b0;
        if (!reset) begin
            case (state)
                S_LOAD: begin
                    bus.mem_addr = load_addr;
                    if (bus.load_valid) begin
                        load_accept = !load_full;
                        load_drop   = load_full;
                        bus.mem_en  = !load_full;
                        if (bus.load_last) begin
                            load_done = 1'b1;
                            state_nxt = S_FETCH;
                        end
                    end
                end
                S_FETCH: begin
                    bus.mem_rw   = 1'b1;
                    bus.mem_addr = fetch_pc;
                    flush        = bus.redirect_valid;
                    issue        = has_credit && !bus.redirect_valid;
                    bus.mem_en   = issue;
                end
                default: begin
                    state_nxt = S_LOAD;
                end
            endcase
        end
    end

    // Load word counter (saturating at capacity) and sticky overflow flag.
    always_ff @(posedge clock) begin
        if (reset) begin
            load_count <= '0;
            load_err   <= 1'b0;
        end else begin
            if (load_accept) begin
                load_count <= load_count + CNT_W'(1);
            end
            if (load_drop) begin
                load_err <= 1'b1;
            end
        end
    end

    // Fetch PC and outstanding-read tracking; a redirect discards the read.
    always_ff @(posedge clock) begin
        if (reset) begin
            fetch_pc    <= PC_BASE_ADDR;
            inflight    <= 1'b0;
            inflight_pc <= PC_BASE_ADDR;
        end else if (load_done) begin
            fetch_pc <= PC_BASE_ADDR;
            inflight <= 1'b0;
        end else if (flush) begin
            fetch_pc <= bus.redirect_pc & ~ADDR_W'(3);
            inflight <= 1'b0;
        end else begin
            inflight <= issue;
            if (issue) begin
                fetch_pc    <= fetch_pc + ADDR_W'(4);
                inflight_pc <= fetch_pc;
            end
        end
    end

    // Skid buffer: shift on pop, capture returning read data behind it.
    always_ff @(posedge clock) begin
        if (reset || flush) begin
            occ <= 2'd0;
        end else begin
            if (pop) begin
                buf_data[0] <= buf_data[1];
                buf_pc[0]   <= buf_pc[1];
            end
            if (push) begin
                buf_data[wr_idx] <= bus.mem_data_out;
                buf_pc[wr_idx]   <= inflight_pc;
            end
            occ <= occ - {1'b0, pop} + {1'b0, push};
        end
    end

    assign bus.load_count  = load_count;
    assign bus.load_err    = load_err;
    assign bus.fetching    = (state == S_FETCH);
    assign bus.instr_valid = (occ != 2'd0);
    assign bus.instr       = buf_data[0];
    assign bus.instr_pc    = buf_pc[0];

    // Capturing into a full buffer with no pop would lose an instruction.
    a_no_overflow: assert property (@(posedge clock) disable iff (reset)
        !(push && !flush && (occ == 2'd2) && !pop));

    // Occupancy never exceeds the two physical entries.
    a_occ_range: assert property (@(posedge clock) disable iff (reset)
        occ <= 2'd2);

    // Reads are only issued during fetch and never while a redirect is pending.
    a_no_issue_on_redirect: assert property (@(posedge clock) disable iff (reset)
        (bus.mem_en && bus.mem_rw) |-> (state == S_FETCH && !bus.redirect_valid));

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Bench for instr_fetch_stage: table-driven preload/overflow vectors, a
// behavioural synchronous memory, and a scoreboard queue of expected
// {pc, instr} pairs checked on every decode handshake.
module tb_instr_fetch_stage;
    localparam int unsigned ADDR_W    = 32;
    localparam int unsigned DATA_W    = 32;
    localparam int unsigned MAX_WORDS = 4;

    typedef struct {
        logic        lv;
        logic [31:0] data;
        logic        last;
        logic        exp_en;
        logic [31:0] exp_addr;
        logic [2:0]  exp_cnt;
        logic        exp_err;
        logic        exp_fetch;
    } load_vec_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
    } exp_t;

    logic clock = 1'b0;
    logic reset;

    instr_fetch_stage_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WORDS(MAX_WORDS)) bus ();

    instr_fetch_stage #(
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .MAX_WORDS   (MAX_WORDS),
        .PC_BASE_ADDR(32'h0)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] pattern(input logic [5:0] i);
        return 32'hA5A5_0000 | 32'(i);
    endfunction

    // Behavioural synchronous instruction memory (64 words).
    logic [31:0] mem [64];
    bit   [63:0] written;
    int          wr_count;
    always @(posedge clock) begin
        if (bus.mem_en) begin
            if (!bus.mem_rw) begin
                mem[bus.mem_addr[7:2]]     <= bus.mem_data_in;
                written[bus.mem_addr[7:2]] <= 1'b1;
                wr_count                   <= wr_count + 1;
            end else begin
                bus.mem_data_out <= written[bus.mem_addr[7:2]] ? mem[bus.mem_addr[7:2]]
                                                               : pattern(bus.mem_addr[7:2]);
            end
        end
    end

    int          n_tests = 0;
    int          n_fail  = 0;
    int          n_hs    = 0;
    logic [31:0] golden [64];
    exp_t        q [$];
    load_vec_t   vecs [12];

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        chk32(name, 32'(act), 32'(exp));
    endtask

    // Sample point mid-cycle; every handshake is scored against the queue.
    task automatic half_a();
        exp_t e;
        @(negedge clock);
        if (bus.instr_valid && bus.instr_ready) begin
            if (q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_instr: got pc %h with nothing expected", bus.instr_pc);
            end else begin
                e = q.pop_front();
                chk32("instr_pc", bus.instr_pc, e.pc);
                chk32("instr", bus.instr, e.data);
                n_hs++;
            end
        end
    endtask

    task automatic half_b();
        @(posedge clock);
        #1;
    endtask

    task automatic cyc();
        half_a();
        half_b();
    endtask

    task automatic push_stream(input logic [31:0] start, input int n);
        logic [31:0] pc;
        for (int k = 0; k < n; k++) begin
            pc = start + 32'(4 * k);
            q.push_back('{pc: pc, data: golden[pc[7:2]]});
        end
    endtask

    task automatic run_vecs(input int first, input int last_i);
        for (int i = first; i <= last_i; i++) begin
            bus.load_valid = vecs[i].lv;
            bus.load_data  = vecs[i].data;
            bus.load_last  = vecs[i].last;
            half_a();
            chk1 ("load_mem_en", bus.mem_en, vecs[i].exp_en);
            chk32("load_mem_addr", bus.mem_addr, vecs[i].exp_addr);
            chk1 ("load_mem_rw", bus.mem_rw, 1'b0);
            if (vecs[i].exp_en) begin
                chk32("load_mem_data_in", bus.mem_data_in, vecs[i].data);
                golden[vecs[i].exp_addr[7:2]] = vecs[i].data;
            end
            half_b();
            chk32("load_count", 32'(bus.load_count), 32'(vecs[i].exp_cnt));
            chk1 ("load_err", bus.load_err, vecs[i].exp_err);
            chk1 ("fetching", bus.fetching, vecs[i].exp_fetch);
        end
        bus.load_valid = 1'b0;
        bus.load_last  = 1'b0;
        bus.load_data  = '0;
    endtask

    // First three fetch cycles: issue at F, nothing visible until F+2.
    task automatic fetch_start();
        half_a();
        chk1 ("f0_mem_en", bus.mem_en, 1'b1);
        chk1 ("f0_mem_rw", bus.mem_rw, 1'b1);
        chk32("f0_mem_addr", bus.mem_addr, 32'h0);
        chk1 ("f0_instr_valid", bus.instr_valid, 1'b0);
        half_b();
        half_a();
        chk32("f1_mem_addr", bus.mem_addr, 32'h4);
        chk1 ("f1_instr_valid", bus.instr_valid, 1'b0);
        half_b();
        half_a();
        chk1 ("f2_instr_valid", bus.instr_valid, 1'b1);
        half_b();
    endtask

    initial begin
        int   hs0;
        int   wr0;
        exp_t head;

        //             lv    data          last  en    addr   cnt   err   fetch
        vecs[0]  = '{1'b0, 32'h0,        1'b1, 1'b0, 32'h0,  3'd0, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 32'h20080005, 1'b0, 1'b1, 32'h0,  3'd1, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 32'h20090007, 1'b0, 1'b1, 32'h4,  3'd2, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 32'h0,        1'b0, 1'b0, 32'h8,  3'd2, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, 32'h01095020, 1'b0, 1'b1, 32'h8,  3'd3, 1'b0, 1'b0};
        vecs[5]  = '{1'b1, 32'h00000000, 1'b1, 1'b1, 32'hC,  3'd4, 1'b0, 1'b1};
        vecs[6]  = '{1'b1, 32'h11110000, 1'b0, 1'b1, 32'h0,  3'd1, 1'b0, 1'b0};
        vecs[7]  = '{1'b1, 32'h11110001, 1'b0, 1'b1, 32'h4,  3'd2, 1'b0, 1'b0};
        vecs[8]  = '{1'b1, 32'h11110002, 1'b0, 1'b1, 32'h8,  3'd3, 1'b0, 1'b0};
        vecs[9]  = '{1'b1, 32'h11110003, 1'b0, 1'b1, 32'hC,  3'd4, 1'b0, 1'b0};
        vecs[10] = '{1'b1, 32'h11110004, 1'b0, 1'b0, 32'h10, 3'd4, 1'b1, 1'b0};
        vecs[11] = '{1'b1, 32'h11110005, 1'b1, 1'b0, 32'h10, 3'd4, 1'b1, 1'b1};

        for (int i = 0; i < 64; i++) golden[i] = pattern(6'(i));

        reset              = 1'b1;
        bus.load_valid     = 1'b0;
        bus.load_data      = '0;
        bus.load_last      = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.instr_ready    = 1'b0;

        // reset state
        half_b();
        half_b();
        half_a();
        chk32("rst_load_count", 32'(bus.load_count), 32'h0);
        chk1 ("rst_load_err", bus.load_err, 1'b0);
        chk1 ("rst_fetching", bus.fetching, 1'b0);
        chk1 ("rst_instr_valid", bus.instr_valid, 1'b0);
        chk1 ("rst_mem_en", bus.mem_en, 1'b0);
        chk1 ("rst_mem_rw", bus.mem_rw, 1'b0);
        chk32("rst_mem_addr", bus.mem_addr, 32'h0);
        half_b();
        reset = 1'b0;

        // preload of the 4-word program
        wr0 = wr_count;
        run_vecs(0, 5);
        chk32("preload_writes", 32'(wr_count - wr0), 32'd4);

        // streaming from the base address
        push_stream(32'h0, 32);
        bus.instr_ready = 1'b1;
        hs0 = n_hs;
        fetch_start();
        for (int k = 0; k < 5; k++) begin
            half_a();
            chk1("stream_instr_valid", bus.instr_valid, 1'b1);
            half_b();
        end
        chk32("stream_throughput", 32'(n_hs - hs0), 32'd6);

        // decode stall for 5 cycles: head held, no further reads
        bus.instr_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            half_a();
            head = q[0];
            chk1 ("stall_mem_en", bus.mem_en, 1'b0);
            chk1 ("stall_instr_valid", bus.instr_valid, 1'b1);
            chk32("stall_head_pc", bus.instr_pc, head.pc);
            chk32("stall_head_instr", bus.instr, head.data);
            half_b();
        end
        bus.instr_ready = 1'b1;
        half_a();
        chk1("release_mem_en", bus.mem_en, 1'b1);
        half_b();
        hs0 = n_hs;
        for (int k = 0; k < 4; k++) cyc();
        chk32("release_throughput", 32'(n_hs - hs0), 32'd4);

        // redirect to 0x41 at cycle R
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h41;
        half_a();
        chk1("redir_r_mem_en", bus.mem_en, 1'b0);
        q.delete();
        push_stream(32'h40, 24);
        half_b();
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        half_a();
        chk1 ("redir_r1_mem_en", bus.mem_en, 1'b1);
        chk32("redir_r1_mem_addr", bus.mem_addr, 32'h40);
        chk1 ("redir_r1_instr_valid", bus.instr_valid, 1'b0);
        half_b();
        half_a();
        chk1("redir_r2_instr_valid", bus.instr_valid, 1'b0);
        half_b();
        half_a();
        chk1 ("redir_r3_instr_valid", bus.instr_valid, 1'b1);
        chk32("redir_r3_instr_pc", bus.instr_pc, 32'h40);
        half_b();
        for (int k = 0; k < 4; k++) cyc();

        // reset mid-fetch
        reset           = 1'b1;
        bus.instr_ready = 1'b0;
        cyc();
        reset = 1'b0;
        half_a();
        chk1 ("midrst_fetching", bus.fetching, 1'b0);
        chk1 ("midrst_instr_valid", bus.instr_valid, 1'b0);
        chk32("midrst_load_count", 32'(bus.load_count), 32'h0);
        chk1 ("midrst_load_err", bus.load_err, 1'b0);
        chk1 ("midrst_mem_en", bus.mem_en, 1'b0);
        chk32("midrst_mem_addr", bus.mem_addr, 32'h0);
        q.delete();
        half_b();

        // overflow reload: 6 words into a 4-word capacity
        wr0 = wr_count;
        run_vecs(6, 11);
        chk32("overflow_writes", 32'(wr_count - wr0), 32'd4);

        // fetch restarts at the base address with the reloaded image
        push_stream(32'h0, 24);
        bus.instr_ready = 1'b1;
        fetch_start();
        for (int k = 0; k < 6; k++) begin
            half_a();
            chk1("sticky_load_err", bus.load_err, 1'b1);
            half_b();
        end
        chk32("reload_writes_after_fetch", 32'(wr_count - wr0), 32'd4);

        // reset clears the sticky error
        reset           = 1'b1;
        bus.instr_ready = 1'b0;
        cyc();
        reset = 1'b0;
        half_a();
        chk1 ("final_load_err", bus.load_err, 1'b0);
        chk32("final_load_count", 32'(bus.load_count), 32'h0);
        chk1 ("final_fetching", bus.fetching, 1'b0);
        half_b();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
